// File: rtl/servo_pkg.sv
// Shared servo-loop definitions: the current-code width used by the ADC,
// the current monitor and the overcurrent guard, plus the guard FSM states.
package servo_pkg;

  localparam int CUR_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_TRIPPED  = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_LOCKOUT  = 2'd3
  } ocg_state_t;

endpackage

// File: rtl/overcurrent_guard_if.sv
// Sample/protection bundle between the current ADC side (master) and the
// overcurrent guard (slave).
interface overcurrent_guard_if #(
  parameter int CUR_W = servo_pkg::CUR_W_DEF,
  parameter int RC_W  = 2
) ();

  logic [CUR_W-1:0] current_code;
  logic             current_valid;
  logic             fault_clear;
  logic             current_high;
  logic             fault_latched;
  logic [RC_W-1:0]  retry_cnt;
  logic [CUR_W-1:0] peak_code;

  modport master (
    output current_code, current_valid, fault_clear,
    input  current_high, fault_latched, retry_cnt, peak_code
  );

  modport slave (
    input  current_code, current_valid, fault_clear,
    output current_high, fault_latched, retry_cnt, peak_code
  );

endinterface

// File: rtl/cooldown_timer.sv
// Loadable down-counter for the overcurrent cooldown window.
// After load, busy stays high for COOLDOWN_CYCLES clocks; done pulses for one
// cycle in the last of them so the consumer can leave on the following edge.
module cooldown_timer #(
  parameter int COOLDOWN_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: reload wins, otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_V;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == LAST_V);

endmodule

// File: rtl/overcurrent_guard.sv
// Overcurrent guard between the current ADC and the duty mux.
// Filters over-threshold samples, trips current_high, waits for release with
// hysteresis, holds a timed cooldown, retries a bounded number of times and
// then latches a lockout that only fault_clear releases.
// Optional build macro OCG_PEAK_CAPTURE_EN: when defined, peak_code tracks the
// largest valid sample since reset or the last lockout clear; otherwise
// peak_code is tied to 0.
//
// state       | meaning
// ST_NORMAL   | counting consecutive over samples, current_high = 0
// ST_TRIPPED  | safe duty forced, waiting for a sample below CLEAR_TH
// ST_COOLDOWN | safe duty forced, samples ignored until the timer expires
// ST_LOCKOUT  | retries exhausted, safe duty forced until fault_clear
module overcurrent_guard
  import servo_pkg::*;
#(
  parameter int CUR_W           = CUR_W_DEF,
  parameter int TRIP_TH         = 3000,
  parameter int CLEAR_TH        = 2800,
  parameter int TRIP_CYCLES     = 16,
  parameter int COOLDOWN_CYCLES = 50000,
  parameter int MAX_RETRIES     = 3,
  localparam int RC_W           = $clog2(MAX_RETRIES + 1)
) (
  input logic clk,
  input logic rst,
  overcurrent_guard_if.slave bus
);

  if (CLEAR_TH >= TRIP_TH) begin : g_bad_thresholds
    $error("overcurrent_guard: CLEAR_TH must be below TRIP_TH");
  end
  if (TRIP_CYCLES < 1 || COOLDOWN_CYCLES < 1 || MAX_RETRIES < 1) begin : g_bad_counts
    $error("overcurrent_guard: TRIP_CYCLES, COOLDOWN_CYCLES and MAX_RETRIES must be >= 1");
  end

  localparam int OC_W = $clog2(TRIP_CYCLES + 1);
  localparam logic [CUR_W-1:0] TRIP_V  = CUR_W'(TRIP_TH);
  localparam logic [CUR_W-1:0] CLEAR_V = CUR_W'(CLEAR_TH);
  localparam logic [OC_W-1:0]  OC_LAST = OC_W'(TRIP_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(MAX_RETRIES);

  // Inputs are registered once so that no output depends combinationally on
  // the ADC bus; every decision below acts on the registered sample.
  logic [CUR_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             clear_q, clear_d;

  ocg_state_t       state_q, state_d;
  logic [OC_W-1:0]  over_q, over_d;
  logic [RC_W-1:0]  retry_q, retry_d;
  logic             current_high_q, current_high_d;
  logic             fault_latched_q, fault_latched_d;

  logic             tmr_load;
  logic             tmr_busy;
  logic             tmr_done;

  // Input capture stage.
  always_comb begin
    code_d  = bus.current_code;
    valid_d = bus.current_valid;
    clear_d = bus.fault_clear;
  end

  // Input capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      clear_q <= clear_d;
    end
  end

  cooldown_timer #(
    .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
  ) u_cooldown_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .busy (tmr_busy),
    .done (tmr_done)
  );

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d  = state_q;
    over_d   = over_q;
    retry_d  = retry_q;
    tmr_load = 1'b0;

    case (state_q)
      ST_NORMAL: begin
        if (valid_q) begin
          if (code_q >= TRIP_V) begin
            if (over_q == OC_LAST) begin
              state_d = ST_TRIPPED;
              over_d  = '0;
              retry_d = (retry_q == RC_MAX) ? retry_q : retry_q + 1'b1;
            end else begin
              over_d = over_q + 1'b1;
            end
          end else begin
            over_d = '0;
          end
        end
      end
      ST_TRIPPED: begin
        if (valid_q && (code_q < CLEAR_V)) begin
          state_d  = ST_COOLDOWN;
          tmr_load = 1'b1;
        end
      end
      ST_COOLDOWN: begin
        // !tmr_busy only matters if the timer were ever idle here; it keeps
        // the FSM from sticking in cooldown.
        if (tmr_done || !tmr_busy) begin
          over_d = '0;
          if (retry_q == RC_MAX) state_d = ST_LOCKOUT;
          else                   state_d = ST_NORMAL;
        end
      end
      ST_LOCKOUT: begin
        if (clear_q) begin
          state_d = ST_NORMAL;
          retry_d = '0;
          over_d  = '0;
        end
      end
      default: begin
        state_d = ST_NORMAL;
        over_d  = '0;
      end
    endcase

    current_high_d  = (state_d != ST_NORMAL);
    fault_latched_d = (state_d == ST_LOCKOUT);
  end

  // FSM state, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_NORMAL;
      over_q          <= '0;
      retry_q         <= '0;
      current_high_q  <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      over_q          <= over_d;
      retry_q         <= retry_d;
      current_high_q  <= current_high_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  assign bus.current_high  = current_high_q;
  assign bus.fault_latched = fault_latched_q;
  assign bus.retry_cnt     = retry_q;

`ifdef OCG_PEAK_CAPTURE_EN
  logic [CUR_W-1:0] peak_q, peak_d;
  logic             lockout_clear;

  assign lockout_clear = (state_q == ST_LOCKOUT) && clear_q;

  // Running maximum of valid samples, wiped by a lockout clear.
  always_comb begin
    peak_d = peak_q;
    if (lockout_clear) begin
      peak_d = '0;
    end else if (valid_q && (code_q > peak_q)) begin
      peak_d = code_q;
    end
  end

  // Peak capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign bus.peak_code = peak_q;
`else
  assign bus.peak_code = '0;
`endif

endmodule
